eth_phy_10g_hdr_err_inject: RTL
===============================

Name: eth_phy_10g_hdr_err_inject

Overview:
Synthesizable sync-header error injector for the RX loopback path, placed between SERDES RX outputs and the eth_phy_10g RX input.
- Replaces the 2-bit sync header of selected 64b/66b blocks with an invalid value (00 or 11) in periodic, burst or pseudo-random patterns, on one or more lanes.
- Lets the team exercise block lock, high-BER and bitslip behaviour in hardware and simulation without hand-written stimulus loops.

Parameters:
DATA_WIDTH, 64, data bits per lane per block
HDR_WIDTH, 2, sync header bits per lane
LANES, 1, number of parallel lanes
CNT_WIDTH, 16, width of the period and burst-length config fields
LFSR_SEED, 32'h0000_0001, reset value of the random-mode LFSR (all-zero is illegal)

Ports:
rx_clk  in  1  block clock
rx_rst  in  1  synchronous active-high reset
in_data  in  LANES*DATA_WIDTH  block payload from SERDES
in_hdr  in  LANES*HDR_WIDTH  sync headers from SERDES
in_valid  in  1  block valid
out_data  out  LANES*DATA_WIDTH  payload, delayed one cycle and never modified
out_hdr  out  LANES*HDR_WIDTH  headers, possibly corrupted
out_valid  out  1  registered in_valid
cfg_enable  in  1  injection enable
cfg_mode  in  2  0 pass, 1 periodic, 2 burst, 3 random
cfg_period  in  CNT_WIDTH  clean blocks between injections
cfg_burst_len  in  CNT_WIDTH  consecutive corrupted blocks (burst mode)
cfg_hdr_value  in  HDR_WIDTH  invalid header to insert
cfg_lane_mask  in  LANES  lanes to corrupt
cfg_rand_thresh  in  16  random-mode injection probability, thresh/65536
clear_count  in  1  synchronous clear of inject_count
inject_active  out  1  high in the cycle out_hdr carries a corrupted block
inject_count  out  32  saturating count of corrupted blocks

Behaviour:
Reset:
- All outputs are 0; FSM is IDLE; LFSR is LFSR_SEED; internal counters are 0.

Latency and validity:
- Latency is exactly 1 cycle for data, header and valid.
- out_data always equals the previous cycle's in_data.
- Counters and LFSR advance only on cycles with in_valid=1.
- With in_valid=0: out_valid=0, out_hdr is the registered in_hdr, and nothing is corrupted.

Corruption:
- A corrupted block has out_hdr lane k = cfg_hdr_value for every k with cfg_lane_mask[k]=1; other lanes pass unchanged.
- inject_active=1 for that cycle.
- inject_count increments by 1 per corrupted block, not per lane, and saturates at 32'hFFFF_FFFF.

FSM states: IDLE, GAP, BURST.
- IDLE: pass-through. If cfg_enable=1 and cfg_mode!=0, latch cfg_period, cfg_burst_len and cfg_mode, then go to GAP with gap_cnt=0.
- Periodic mode, GAP: each valid block increments gap_cnt. When gap_cnt reaches period_l-1, the next valid block is corrupted and gap_cnt returns to 0. The result is one corrupted block per period_l+1 valid blocks.
- Burst mode: GAP counts period_l clean valid blocks, then moves to BURST. BURST corrupts burst_l valid blocks, then returns to GAP.
- Random mode: stays in GAP. Each valid block advances the LFSR (x^32+x^22+x^2+x+1, shift left, 1 step per block). The block is corrupted if LFSR[15:0] < cfg_rand_thresh. cfg_rand_thresh is read live, not latched.
- Any state: cfg_enable=0 or cfg_mode=0 returns the FSM to IDLE on the next edge. A block presented in that same cycle is not corrupted.
- Latched config changes only via IDLE. Live cfg_* edits mid-run are ignored, except cfg_hdr_value, cfg_lane_mask and cfg_rand_thresh, which take effect immediately.

Boundary conditions:
- cfg_period=0 is treated as 1.
- cfg_burst_len=0 in burst mode means no corruption; the FSM loops GAP→GAP.
- cfg_hdr_value of 01 or 10 is accepted and inserted verbatim.
- clear_count and an injection in the same cycle: clear wins, inject_count=0.
- rx_rst mid-burst: immediate return to reset state. The LFSR reloads LFSR_SEED, so random sequences are reproducible after reset.

Optional Feature:
HDR_ERR_INJECT_TOGGLE_EN
- Defined: corrupted blocks alternate between 2'b00 and 2'b11, starting with 00 after reset and after each IDLE exit. cfg_hdr_value is ignored. The toggle flop advances per corrupted block.
- Undefined: cfg_hdr_value is used; no toggle logic is present.

Decomposition:
- Package eth_phy_10g_pkg holds:
  - the mode constants MODE_PASS, MODE_PERIODIC, MODE_BURST, MODE_RANDOM;
  - the sync header constants SYNC_DATA=2'b10, SYNC_CTRL=2'b01, SYNC_BAD0=2'b00, SYNC_BAD1=2'b11;
  - the FSM state encoding.
- Sub-module eth_phy_10g_lfsr32 is a 32-bit Galois LFSR with advance enable and seed parameter, reusable by other PCS test blocks.

Test Plan:
1. Mode 1, period=4, burst irrelevant, lane_mask=1, hdr=00, continuous valid 20 blocks → corrupted blocks at valid index 4, 9, 14, 19; inject_count=4; out_data equals in_data delayed 1 cycle.
2. Mode 2, period=3, burst_len=2, hdr=11, 14 valid blocks → pattern CCCBBCCCBBCCCB (C=clean, B=bad); inject_count=5.
3. Mode 3, thresh=0 for 100 blocks → zero injections; thresh=16'hFFFF → 100 injections minus blocks with LFSR[15:0]=FFFF, matched against a reference LFSR model; rx_rst then replay gives an identical sequence.
4. LANES=4, mode 1, period=1, lane_mask=4'b0101 → lanes 0 and 2 get the bad header, lanes 1 and 3 pass; inject_count increments by 1 per block.
5. Mode 2 mid-burst: cfg_enable=0 → next block clean, FSM in IDLE. Separately, clear_count asserted together with an injection → inject_count=0. Count preloaded via force to FFFF_FFFE, two injections → FFFF_FFFF.
6. Connected to eth_phy_10g, mode 1, period=1, hdr toggle (HDR_ERR_INJECT_TOGGLE_EN) → rx_block_lock=0, serdes_rx_bitslip pulses, rx_high_ber=1 within 125 µs-scaled COUNT_125US.

Source files
------------

// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the eth_phy_10g PCS test blocks: injector modes,
// 64b/66b sync header values and the injector FSM state encoding.
package eth_phy_10g_pkg;

  localparam logic [1:0] MODE_PASS     = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_BURST    = 2'd2;
  localparam logic [1:0] MODE_RANDOM   = 2'd3;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [1:0] SYNC_BAD0 = 2'b00;
  localparam logic [1:0] SYNC_BAD1 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    BURST = 2'd2
  } inj_state_t;

endpackage

// File: rtl/eth_phy_10g_lfsr32.sv
// 32-bit Galois LFSR, x^32+x^22+x^2+x+1, shifting left one step per advance.
module eth_phy_10g_lfsr32 #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] value
);

  // Feedback taps for x^22, x^2, x^1 and x^0 once the x^32 term falls out.
  localparam logic [31:0] TAPS = 32'h0040_0007;

  always_ff @(posedge clk) begin
    if (rst)
      value <= SEED;
    else if (advance)
      value <= {value[30:0], 1'b0} ^ (value[31] ? TAPS : 32'h0);
  end

endmodule

// File: rtl/eth_phy_10g_hdr_err_inject.sv
// Sync-header error injector for the RX loopback path (periodic, burst, random).
// Optional macro HDR_ERR_INJECT_TOGGLE_EN alternates the bad header 00/11.
module eth_phy_10g_hdr_err_inject #(
  parameter int          DATA_WIDTH = 64,
  parameter int          HDR_WIDTH  = 2,
  parameter int          LANES      = 1,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [LANES*HDR_WIDTH-1:0]  in_hdr,
  input  logic                        in_valid,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES*HDR_WIDTH-1:0]  out_hdr,
  output logic                        out_valid,
  input  logic                        cfg_enable,
  input  logic [1:0]                  cfg_mode,
  input  logic [CNT_WIDTH-1:0]        cfg_period,
  input  logic [CNT_WIDTH-1:0]        cfg_burst_len,
  input  logic [HDR_WIDTH-1:0]        cfg_hdr_value,
  input  logic [LANES-1:0]            cfg_lane_mask,
  input  logic [15:0]                 cfg_rand_thresh,
  input  logic                        clear_count,
  output logic                        inject_active,
  output logic [31:0]                 inject_count
);

  import eth_phy_10g_pkg::*;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  inj_state_t                 state;
  logic [1:0]                 mode_l;
  logic [CNT_WIDTH-1:0]       period_l;
  logic [CNT_WIDTH-1:0]       burst_l;
  logic [CNT_WIDTH-1:0]       gap_cnt;
  logic [CNT_WIDTH-1:0]       burst_cnt;
  logic [31:0]                lfsr;
  logic                       lfsr_unused;
  logic                       run;
  logic                       corrupt;
  logic                       lfsr_adv;
  logic [HDR_WIDTH-1:0]       bad_hdr;
  logic [LANES*HDR_WIDTH-1:0] hdr_next;

  assign run         = cfg_enable && (cfg_mode != MODE_PASS);
  assign lfsr_adv    = in_valid && run && (state == GAP) && (mode_l == MODE_RANDOM);
  assign lfsr_unused = ^lfsr[31:16];

  eth_phy_10g_lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (rx_clk),
    .rst     (rx_rst),
    .advance (lfsr_adv),
    .value   (lfsr)
  );

  // A block is only ever corrupted while the injector is running.
  always_comb begin
    corrupt = 1'b0;
    if (in_valid && run) begin
      case (state)
        GAP: begin
          case (mode_l)
            MODE_PERIODIC: corrupt = (gap_cnt == period_l);
            MODE_RANDOM:   corrupt = (lfsr[15:0] < cfg_rand_thresh);
            default:       corrupt = 1'b0;
          endcase
        end
        BURST:   corrupt = 1'b1;
        default: corrupt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state     <= IDLE;
      mode_l    <= MODE_PASS;
      period_l  <= '0;
      burst_l   <= '0;
      gap_cnt   <= '0;
      burst_cnt <= '0;
    end else if (!run) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          mode_l    <= cfg_mode;
          period_l  <= (cfg_period == '0) ? ONE : cfg_period;
          burst_l   <= cfg_burst_len;
          gap_cnt   <= '0;
          burst_cnt <= '0;
          state     <= GAP;
        end
        GAP: begin
          if (in_valid) begin
            case (mode_l)
              MODE_PERIODIC: gap_cnt <= corrupt ? '0 : gap_cnt + ONE;
              MODE_BURST: begin
                if (gap_cnt == period_l - ONE) begin
                  gap_cnt <= '0;
                  if (burst_l != '0)
                    state <= BURST;
                end else begin
                  gap_cnt <= gap_cnt + ONE;
                end
              end
              default: gap_cnt <= gap_cnt;
            endcase
          end
        end
        BURST: begin
          if (in_valid) begin
            if (burst_cnt == burst_l - ONE) begin
              burst_cnt <= '0;
              state     <= GAP;
            end else begin
              burst_cnt <= burst_cnt + ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HDR_ERR_INJECT_TOGGLE_EN
  logic toggle;
  logic hdr_unused;

  assign hdr_unused = ^cfg_hdr_value;

  // Restart at 00 on every run so the pattern is repeatable per enable.
  always_ff @(posedge rx_clk) begin
    if (rx_rst || state == IDLE)
      toggle <= 1'b0;
    else if (corrupt)
      toggle <= ~toggle;
  end

  assign bad_hdr = {HDR_WIDTH{toggle}};
`else
  assign bad_hdr = cfg_hdr_value;
`endif

  always_comb begin
    hdr_next = in_hdr;
    for (int k = 0; k < LANES; k++) begin
      if (corrupt && cfg_lane_mask[k])
        hdr_next[k*HDR_WIDTH +: HDR_WIDTH] = bad_hdr;
    end
  end

  // Count is per corrupted block regardless of lane count; clear has priority.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      out_data      <= '0;
      out_hdr       <= '0;
      out_valid     <= 1'b0;
      inject_active <= 1'b0;
      inject_count  <= '0;
    end else begin
      out_data      <= in_data;
      out_hdr       <= hdr_next;
      out_valid     <= in_valid;
      inject_active <= corrupt;
      if (clear_count)
        inject_count <= '0;
      else if (corrupt && inject_count != 32'hFFFF_FFFF)
        inject_count <= inject_count + 32'd1;
    end
  end

endmodule
